// File: rtl/sram_stream_pkg.sv
// Shared types and constants for the sram read streamer.
package sram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int FIFO_DEPTH     = 2;
  localparam int DEFAULT_DEPTH  = 2048;
  localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/sram_rd_streamer_skid_fifo2.sv
// Two-entry synchronous FIFO that absorbs words captured from the sram while
// the downstream stream is stalled. Push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module skid_fifo2
  import sram_stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
)(
  input  logic              CLK,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        cnt,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_cnt;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign w_pop_ok  = pop && (r_cnt != 2'd0);
  assign w_push_ok = push && ((r_cnt != 2'(FIFO_DEPTH)) || w_pop_ok);

  // Storage write; cleared on reset so the stream data output starts at zero.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keeps the count.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop_ok)  r_rd_ptr <= ~r_rd_ptr;
      if (w_push_ok && !w_pop_ok)      r_cnt <= r_cnt + 2'd1;
      else if (!w_push_ok && w_pop_ok) r_cnt <= r_cnt - 2'd1;
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign cnt   = r_cnt;
  assign full  = (r_cnt == 2'(FIFO_DEPTH));
  assign empty = (r_cnt == 2'd0);

endmodule

// File: rtl/sram_rd_streamer.sv
// Burst read controller for a single-port sram with 1-cycle read latency.
// Issues consecutive reads and presents the returned words as a valid/ready
// stream; reads are only issued when a FIFO slot is guaranteed for the data.
module sram_rd_streamer
  import sram_stream_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W  = ADDR_W + 1
)(
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [DATA_W-1:0] sram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_sram_a;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_popped;
  logic              r_inflight;
  logic              w_start_ok;
  logic              w_issue;
  logic              w_pop;
  logic [1:0]        w_fifo_cnt;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [2:0]        w_occ;

  // Address advance with wrap at the end of the attached memory.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] n;
    if (a == ADDR_W'(DEPTH - 1)) n = '0;
    else                         n = a + ADDR_W'(1);
    return n;
  endfunction

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_pop      = !w_fifo_empty && out_ready;
  // Slots committed after this cycle: buffered words plus the read in flight,
  // minus the word leaving now.
  assign w_occ      = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue    = (r_state == RUN) && (r_issued < r_len) &&
                      (w_occ < 3'(FIFO_DEPTH)) && !(w_fifo_full && !w_pop);

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and state-derived status outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = (length == '0) ? FINISH : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_pop && ((r_popped + LEN_W'(1)) == r_len)) w_state_nxt = FINISH;
      end
      FINISH: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Burst capture, issue/pop counters, address and in-flight tracking.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_sram_a   <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_popped   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_start_ok) begin
        r_addr   <= base_addr;
        r_len    <= length;
        r_issued <= '0;
        r_popped <= '0;
      end else begin
        if (w_issue) begin
          r_addr   <= next_addr(r_addr);
          r_sram_a <= r_addr;
          r_issued <= r_issued + LEN_W'(1);
        end
        if (w_pop) r_popped <= r_popped + LEN_W'(1);
      end
    end
  end

  assign sram_cen  = !w_issue;
  assign sram_wen  = 1'b1;
  assign sram_a    = w_issue ? r_addr : r_sram_a;
  assign out_valid = !w_fifo_empty;

  skid_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (r_inflight),
    .din   (sram_q),
    .pop   (w_pop),
    .dout  (out_data),
    .cnt   (w_fifo_cnt),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Bench for sram_rd_streamer attached to a small behavioural sram whose
// word i holds 16'hA000 + i. Expected words are queued when a burst starts and
// matched in order as the stream hands them out.
module tb_sram_rd_streamer;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int LEN_W  = 5;

  logic              CLK = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic              sram_cen;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] mem [DEPTH];
  int                iss_cnt;
  int                pop_cnt;
  logic              prev_stall;
  logic [DATA_W-1:0] prev_data;

  always #5 CLK = ~CLK;

  sram_rd_streamer #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_a    (sram_a),
    .sram_q    (sram_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Behavioural sram: registered read, data valid the cycle after the read.
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 16'hA000 + 16'(i);
  always @(posedge CLK) if (!sram_cen && sram_wen) sram_q <= mem[sram_a];

  // Scoreboard and stream-protocol monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (reset) begin
      iss_cnt    = 0;
      pop_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_fail++;
          $display("FAIL sb_stall_hold: valid=%b data=%h, want valid=1 data=%h", out_valid, out_data, prev_data);
        end
      end
      if (sram_cen === 1'b0) iss_cnt++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_tests++;
        pop_cnt++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got data=%h, want no transfer", out_data);
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_fail++;
            $display("FAIL sb_data: got %h, want %h", out_data, e);
          end
        end
      end
      if (busy === 1'b1) begin
        n_tests++;
        if (iss_cnt - pop_cnt > 2) begin
          n_fail++;
          $display("FAIL sb_outstanding: got %0d words committed, want at most 2", iss_cnt - pop_cnt);
        end
      end
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_data  = out_data;
    end
  end

  // Pulse start for one cycle; on return the bench is inside cycle 1.
  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
    @(posedge CLK); #1;
    start     = 1'b1;
    base_addr = b;
    length    = l;
    for (int i = 0; i < int'(l); i++)
      exp_q.push_back(16'hA000 + 16'((int'(b) + i) % DEPTH));
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (sram_cen !== 1'b1)  begin n_fail++; $display("FAIL reset_cen: got %b want 1", sram_cen); end
    n_tests++; if (sram_wen !== 1'b1)  begin n_fail++; $display("FAIL reset_wen: got %b want 1", sram_wen); end
    n_tests++; if (sram_a !== 4'd0)    begin n_fail++; $display("FAIL reset_addr: got %h want 0", sram_a); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_tests++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
    @(posedge CLK); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cen_low;
    logic [DATA_W-1:0] want;
    cen_low = 0;
    out_ready = 1'b1;
    do_start(4'd2, 5'd4);
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      if (sram_cen === 1'b0) cen_low++;
      n_tests++;
      if (out_valid !== ((k >= 3) && (k <= 6))) begin
        n_fail++; $display("FAIL basic_valid c%0d: got %b want %b", k, out_valid, (k >= 3) && (k <= 6));
      end
      if (k >= 3 && k <= 6) begin
        want = 16'hA000 + 16'(k - 1);
        n_tests++;
        if (out_data !== want) begin
          n_fail++; $display("FAIL basic_data c%0d: got %h want %h", k, out_data, want);
        end
      end
      n_tests++;
      if (done !== (k == 7)) begin
        n_fail++; $display("FAIL basic_done c%0d: got %b want %b", k, done, k == 7);
      end
      n_tests++;
      if (busy !== (k <= 6)) begin
        n_fail++; $display("FAIL basic_busy c%0d: got %b want %b", k, busy, k <= 6);
      end
    end
    n_tests++; if (cen_low != 4) begin n_fail++; $display("FAIL basic_cen_count: got %0d want 4", cen_low); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] got_a [4];
    logic [ADDR_W-1:0] want_a;
    int n;
    bit seen_done;
    n = 0; seen_done = 0;
    out_ready = 1'b1;
    do_start(4'd14, 5'd4);
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (sram_cen === 1'b0) begin
        if (n < 4) got_a[n] = sram_a;
        n++;
      end
      if (done === 1'b1) seen_done = 1;
    end
    n_tests++; if (n != 4) begin n_fail++; $display("FAIL wrap_cen_count: got %0d want 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      want_a = 4'((14 + i) % DEPTH);
      n_tests++;
      if (got_a[i] !== want_a) begin
        n_fail++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, got_a[i], want_a);
      end
    end
    n_tests++; if (!seen_done) begin n_fail++; $display("FAIL wrap_done: got no done want done"); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_len0();
    int cen_low;
    cen_low = 0;
    out_ready = 1'b1;
    do_start(4'd5, 5'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      if (sram_cen === 1'b0) cen_low++;
      n_tests++;
      if (done !== (k == 1)) begin
        n_fail++; $display("FAIL len0_done c%0d: got %b want %b", k, done, k == 1);
      end
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL len0_idle c%0d: got valid=%b busy=%b want 0 0", k, out_valid, busy);
      end
    end
    n_tests++; if (cen_low != 0) begin n_fail++; $display("FAIL len0_cen_count: got %0d want 0", cen_low); end
  endtask

  task automatic test_backpressure();
    logic pat [4];
    bit seen_done;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    seen_done = 0;
    out_ready = pat[0];
    do_start(4'd0, 5'd8);
    for (int k = 1; k <= 100 && !seen_done; k++) begin
      @(negedge CLK);
      if (done === 1'b1) seen_done = 1;
      @(posedge CLK); #1;
      out_ready = pat[k % 4];
    end
    out_ready = 1'b1;
    n_tests++; if (!seen_done) begin n_fail++; $display("FAIL bp_done: got timeout want done"); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_ignored_start();
    int cen_low;
    bit seen_done;
    cen_low = 0; seen_done = 0;
    out_ready = 1'b1;
    do_start(4'd4, 5'd3);
    @(negedge CLK);
    if (sram_cen === 1'b0) cen_low++;
    @(posedge CLK); #1;
    start = 1'b1; base_addr = 4'd9; length = 5'd5;
    @(negedge CLK);
    if (sram_cen === 1'b0) cen_low++;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int k = 0; k < 50 && !seen_done; k++) begin
      @(negedge CLK);
      if (sram_cen === 1'b0) cen_low++;
      if (done === 1'b1) seen_done = 1;
    end
    n_tests++; if (!seen_done) begin n_fail++; $display("FAIL ign_done: got timeout want done"); end
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (sram_cen === 1'b0) cen_low++;
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy_after: got %b want 0", busy); end
    n_tests++; if (cen_low != 3) begin n_fail++; $display("FAIL ign_cen_count: got %0d want 3", cen_low); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ign_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int cen_low;
    bit seen_done;
    cen_low = 0; seen_done = 0;
    out_ready = 1'b1;
    do_start(4'd0, 5'd8);
    repeat (3) @(negedge CLK);
    @(posedge CLK); #1;
    reset = 1'b1;
    for (int k = 4; k <= 5; k++) begin
      @(negedge CLK);
      n_tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || sram_cen !== 1'b1) begin
        n_fail++;
        $display("FAIL rstmid_c%0d: got busy=%b valid=%b cen=%b want 0 0 1", k, busy, out_valid, sram_cen);
      end
      if (k == 4) begin @(posedge CLK); #1; end
    end
    exp_q.delete();
    @(posedge CLK); #1;
    reset = 1'b0;
    do_start(4'd5, 5'd3);
    for (int k = 1; k <= 40 && !seen_done; k++) begin
      @(negedge CLK);
      if (sram_cen === 1'b0) cen_low++;
      if (done === 1'b1) seen_done = 1;
    end
    n_tests++; if (!seen_done) begin n_fail++; $display("FAIL rstmid_done: got timeout want done"); end
    n_tests++; if (cen_low != 3) begin n_fail++; $display("FAIL rstmid_cen_count: got %0d want 3", cen_low); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_drain: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_len0();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
